// File: rtl/regfile_checker_if.sv
// Bus bundle between regfile_checker and its driver: run control, expected-table
// write port, register-file read port and result outputs.
interface regfile_checker_if #(
  parameter int NREGS = 32,
  parameter int WIDTH = 32
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int CW = $clog2(NREGS + 1);

  logic             start;
  logic             halt;
  logic             exp_we;
  logic [AW-1:0]    exp_addr;
  logic [WIDTH-1:0] exp_data;
  logic             exp_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CW-1:0]    err_count;
  logic [AW-1:0]    first_err_idx;
  logic [WIDTH-1:0] first_err_got;
  logic [WIDTH-1:0] first_err_exp;

  modport slave (
    input  start, halt, exp_we, exp_addr, exp_data, exp_en, rd_data,
    output rd_addr, busy, done, pass, err_count,
           first_err_idx, first_err_got, first_err_exp
  );

  modport master (
    output start, halt, exp_we, exp_addr, exp_data, exp_en, rd_data,
    input  rd_addr, busy, done, pass, err_count,
           first_err_idx, first_err_got, first_err_exp
  );
endinterface

// File: rtl/regfile_checker.sv
// Architectural-state self-check: waits for halt or timeout, scans the register
// file through a 1-cycle-latency read port and compares against an expected table.
module regfile_checker #(
  parameter int NREGS   = 32,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 10000
) (
  input logic              clk,
  input logic              rst,
  regfile_checker_if.slave bus
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int CW = $clog2(NREGS + 1);
  localparam int SW = $clog2(NREGS + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SCAN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] exp_q [NREGS];
  logic [NREGS-1:0] en_q;
  logic [TW-1:0]    cnt_q;
  logic [SW-1:0]    scan_q;
  logic [AW-1:0]    rd_addr_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [CW-1:0]    err_q;
  logic [AW-1:0]    first_idx_q;
  logic [WIDTH-1:0] first_got_q;
  logic [WIDTH-1:0] first_exp_q;

  logic             table_open;
  logic             cmp_valid;
  logic [AW-1:0]    cmp_idx;
  logic             mismatch;
  logic             last_scan;
  logic             run_exit;
  logic [CW-1:0]    err_d;
  logic [AW-1:0]    rd_addr_d;

  // scan_q counts SCAN cycles; cycle k>0 compares the data fetched for address k-1
  always_comb begin
    table_open = (state_q == S_IDLE) || (state_q == S_DONE);
    cmp_valid  = (state_q == S_SCAN) && (scan_q != '0);
    cmp_idx    = AW'(scan_q - SW'(1));
    mismatch   = cmp_valid && en_q[cmp_idx] && (bus.rd_data !== exp_q[cmp_idx]);
    err_d      = err_q + CW'(mismatch);
    last_scan  = (scan_q == SW'(NREGS));
    run_exit   = bus.halt || (cnt_q == TW'(TIMEOUT - 1));
    rd_addr_d  = AW'(NREGS - 1);
    if (scan_q < SW'(NREGS - 1)) begin
      rd_addr_d = AW'(scan_q + SW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        exp_q[i] <= '0;
      end
    end else if (table_open && bus.exp_we) begin
      exp_q[bus.exp_addr] <= bus.exp_data;
      en_q[bus.exp_addr]  <= bus.exp_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      scan_q      <= '0;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      first_idx_q <= '0;
      first_got_q <= '0;
      first_exp_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            first_idx_q <= '0;
            first_got_q <= '0;
            first_exp_q <= '0;
          end
        end
        S_RUN: begin
          if (run_exit) begin
            state_q   <= S_SCAN;
            scan_q    <= '0;
            rd_addr_q <= '0;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        S_SCAN: begin
          scan_q    <= scan_q + SW'(1);
          rd_addr_q <= rd_addr_d;
          err_q     <= err_d;
          // err_q still zero means this is the run's first mismatch
          if (mismatch && (err_q == '0)) begin
            first_idx_q <= cmp_idx;
            first_got_q <= bus.rd_data;
            first_exp_q <= exp_q[cmp_idx];
          end
          if (last_scan) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_addr       = rd_addr_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = first_idx_q;
  assign bus.first_err_got = first_got_q;
  assign bus.first_err_exp = first_exp_q;
endmodule

// File: tb/tb_regfile_checker.sv
// Directed plus randomized checks of regfile_checker against a behavioural model
// of the expected table and register file.
module tb_regfile_checker;
  localparam int NREGS   = 32;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 10000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_checker_if #(.NREGS(NREGS), .WIDTH(WIDTH)) bus ();

  regfile_checker #(.NREGS(NREGS), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Register file seen by the checker: synchronous read, one cycle latency
  logic [WIDTH-1:0] rf [NREGS];
  always @(posedge clk) bus.rd_data <= rf[bus.rd_addr];

  logic [WIDTH-1:0] m_exp [NREGS];
  bit               m_en  [NREGS];

  int n_pass  = 0;
  int n_total = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREGS; i++) begin
      m_exp[i] = '0;
      m_en[i]  = 1'b0;
    end
  endtask

  task automatic wr(input int a, input logic [WIDTH-1:0] d, input bit en);
    bus.exp_we   = 1'b1;
    bus.exp_addr = 5'(a);
    bus.exp_data = d;
    bus.exp_en   = en;
    step();
    bus.exp_we = 1'b0;
    m_exp[a] = d;
    m_en[a]  = en;
  endtask

  // halt_cyc: RUN cycle (1-based) on which halt is high, 0 = never.
  // poke_cyc: RUN cycle on which a table write to x8 and a start pulse are issued.
  task automatic run(input string tag, input int halt_cyc, input int poke_cyc);
    int n;
    int lat;
    int e_err;
    int e_idx;
    logic [WIDTH-1:0] e_got;
    logic [WIDTH-1:0] e_exp;
    e_err = 0; e_idx = 0; e_got = '0; e_exp = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (m_en[i] && rf[i] != m_exp[i]) begin
        if (e_err == 0) begin
          e_idx = i; e_got = rf[i]; e_exp = m_exp[i];
        end
        e_err++;
      end
    end
    lat = ((halt_cyc != 0 && halt_cyc < TIMEOUT) ? halt_cyc : TIMEOUT) + NREGS + 1;

    bus.start = 1'b1;
    step();
    bus.start  = 1'b0;
    bus.exp_we = 1'b0;
    chk({tag, "_busy_run"}, 64'(bus.busy), 64'd1);
    chk({tag, "_done_run"}, 64'(bus.done), 64'd0);
    n = 0;
    while (!bus.done && n < TIMEOUT + NREGS + 100) begin
      bus.halt = (halt_cyc != 0 && n + 1 == halt_cyc);
      if (poke_cyc != 0 && n + 1 == poke_cyc) begin
        bus.exp_we   = 1'b1;
        bus.exp_addr = 5'd8;
        bus.exp_data = 32'h55;
        bus.exp_en   = 1'b1;
        bus.start    = 1'b1;
      end
      step();
      n++;
      bus.halt   = 1'b0;
      bus.exp_we = 1'b0;
      bus.start  = 1'b0;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_pass"}, 64'(bus.pass), 64'(e_err == 0));
    chk({tag, "_err_count"}, 64'(bus.err_count), 64'(e_err));
    chk({tag, "_first_idx"}, 64'(bus.first_err_idx), 64'(e_idx));
    chk({tag, "_first_got"}, 64'(bus.first_err_got), 64'(e_got));
    chk({tag, "_first_exp"}, 64'(bus.first_err_exp), 64'(e_exp));
    chk({tag, "_rd_addr_end"}, 64'(bus.rd_addr), 64'(NREGS - 1));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_pass"}, 64'(bus.pass), 64'd0);
    chk({tag, "_err_count"}, 64'(bus.err_count), 64'd0);
    chk({tag, "_first_idx"}, 64'(bus.first_err_idx), 64'd0);
    chk({tag, "_first_got"}, 64'(bus.first_err_got), 64'd0);
    chk({tag, "_first_exp"}, 64'(bus.first_err_exp), 64'd0);
    chk({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.start = 1'b0; bus.halt = 1'b0; bus.exp_we = 1'b0;
    bus.exp_addr = '0; bus.exp_data = '0; bus.exp_en = 1'b0;
    for (int i = 0; i < NREGS; i++) rf[i] = 32'hA000 + i;
    clear_model();
    step(); step();
    rst = 1'b0;
    chk_zero("reset");

    // All-match with full timeout
    wr(8, 1, 1); wr(9, 2, 1); wr(18, 3, 1); wr(19, 4, 1); wr(20, 5, 1); wr(21, 6, 1);
    rf[8] = 1; rf[9] = 2; rf[18] = 3; rf[19] = 4; rf[20] = 5; rf[21] = 6;
    run("allmatch", 0, 0);

    rf[19] = 7;
    run("single", 1, 0);

    rf[19] = 4; rf[9] = 0; rf[20] = 9;
    run("multi", 3, 0);

    // Masked entry plus early halt on RUN cycle 50
    rf[9] = 2; rf[20] = 5; rf[5] = 32'hDEAD;
    wr(5, 0, 0);
    run("earlyhalt", 50, 0);

    // Write and start while RUN are both ignored
    run("busywrite", 40, 10);
    wr(8, 32'h55, 1);
    run("donewrite", 20, 0);

    // Back-to-back writes to one address, then a write coincident with start
    wr(12, 32'h111, 1); wr(12, 32'h222, 1);
    rf[12] = 32'h222; rf[8] = 32'h55;
    bus.exp_we = 1'b1; bus.exp_addr = 5'd21; bus.exp_data = 32'h77; bus.exp_en = 1'b1;
    m_exp[21] = 32'h77; m_en[21] = 1'b1;
    run("wr_with_start", 5, 0);

    // Reset in the middle of SCAN
    bus.start = 1'b1; step(); bus.start = 1'b0;
    bus.halt = 1'b1; step(); bus.halt = 1'b0;
    n = 0;
    while (bus.rd_addr != 5'd10 && n < 100) begin step(); n++; end
    chk("midscan_reach_idx10", 64'(bus.rd_addr), 64'd10);
    rst = 1'b1; step(); rst = 1'b0;
    clear_model();
    chk_zero("midscan_rst");
    run("empty_table", 7, 0);

    // Randomized tables, register contents and halt points
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NREGS; i++) begin
        wr(i, $urandom, ($urandom_range(0, 2) != 0));
        rf[i] = ($urandom_range(0, 5) == 0) ? $urandom : m_exp[i];
      end
      run($sformatf("rand%0d", r), $urandom_range(1, 60), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
